// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ requesters.
// Grants are registered and bounded to MAX_BURST beats; the write data path is combinational.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);
    localparam logic [IdW-1:0]  LastIdx  = IdW'(NUM_REQ - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [IdW-1:0]  last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            active;
    logic            owner_valid;
    logic            found;
    logic [IdW-1:0]  next_owner;
    int unsigned     idx;

    // Gating on rst_n keeps a beat from slipping out during the reset cycle itself.
    assign active     = rst_n && (state_q == StGrant);
    assign busy       = active;
    assign grant_id   = grant_q;
    assign fifo_wr_en = |req_ready;

    always_comb begin
        req_ready   = '0;
        fifo_din    = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == IdW'(i)) begin
                owner_valid  = req_valid[i];
                req_ready[i] = active && req_valid[i] && !fifo_full;
                if (active) begin
                    fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        found      = 1'b0;
        next_owner = grant_q;
        idx        = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_q) + k) % NUM_REQ;
            if (!found && req_valid[IdW'(idx)]) begin
                found      = 1'b1;
                next_owner = IdW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = next_owner;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!owner_valid) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                    cnt_d   = '0;
                end else if (fifo_wr_en) begin
                    if (cnt_q == LastBeat) begin
                        state_d = StIdle;
                        last_d  = grant_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= LastIdx;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester traffic, expected writes queued
// up front and popped by an independent monitor on every FIFO write.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    typedef struct {
        int id;
        int data;
        int gap;   // required cycles since previous write; 0 = don't care
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] src_q[4][$];

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   cyc      = 0;
    int   last_wr  = 0;

    logic force_full = 1'b0;
    logic use_fifo   = 1'b0;
    logic rd_pulse   = 1'b0;
    int   fifo_cnt   = 0;

    logic [3:0] xfer;
    logic       wr_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic offer(input int id, input int data);
        src_q[id].push_back(8'(data));
    endtask

    task automatic expect_wr(input int id, input int data, input int gap);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_data[i*8 +: 8] = src_q[i][0];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
        fifo_full = force_full || (use_fifo && fifo_cnt >= 15);
    endtask

    // Requester and FIFO-occupancy model: handshakes seen mid-cycle retire at the next edge.
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            xfer    = req_valid & req_ready;
            wr_seen = fifo_wr_en;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            if (use_fifo) fifo_cnt = fifo_cnt + (wr_seen ? 1 : 0) - (rd_pulse ? 1 : 0);
            rd_pulse = 1'b0;
            drive_reqs();
        end
    end

    // Monitor: every FIFO write must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_din", int'(fifo_din), e.data);
                    check("wr_grant", int'(grant_id), e.id);
                    check("wr_ready_onehot", int'(req_ready), 1 << e.id);
                    check("wr_while_full", int'(fifo_full), 0);
                    if (e.gap != 0) check("wr_gap", cyc - last_wr, e.gap);
                end
                last_wr = cyc;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        for (int i = 0; i < 4; i++) src_q[i].delete();
        exp_q.delete();
        force_full = 1'b0;
        use_fifo   = 1'b0;
        rd_pulse   = 1'b0;
        fifo_cnt   = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_en", int'(fifo_wr_en), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_grant", int'(grant_id), 0);
        check("rst_din", int'(fifo_din), 0);
        @(posedge clk);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int beats, input int bound);
        int seen = 0;
        int n    = 0;
        while (seen < beats && n < bound) begin
            @(negedge clk);
            n++;
            if (fifo_wr_en) seen++;
        end
        check("beats_seen", seen, beats);
    endtask

    initial begin
        // Single requester, short burst, release when valid drops
        do_reset();
        offer(1, 'hA1); offer(1, 'hA2); offer(1, 'hA3);
        expect_wr(1, 'hA1, 0); expect_wr(1, 'hA2, 1); expect_wr(1, 'hA3, 1);
        wait_drain(50);
        repeat (3) @(negedge clk);
        check("t1_busy_after", int'(busy), 0);
        check("t1_grant_hold", int'(grant_id), 1);
        check("t1_wr_idle", int'(fifo_wr_en), 0);

        // All requesters valid: round-robin 0,1,2,3,0 with 4-beat bursts
        do_reset();
        for (int k = 0; k < 8; k++) offer(0, k);
        for (int i = 1; i < 4; i++) for (int k = 0; k < 4; k++) offer(i, i * 16 + k);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) expect_wr(i, i * 16 + k, (k == 0) ? ((i == 0) ? 0 : 2) : 1);
        end
        for (int k = 4; k < 8; k++) expect_wr(0, k, (k == 4) ? 2 : 1);
        wait_drain(200);

        // FIFO full after beat 2 of req2 for 5 cycles
        do_reset();
        for (int k = 1; k <= 4; k++) offer(2, 'h20 + k);
        offer(3, 'h31); offer(3, 'h32);
        expect_wr(2, 'h21, 0); expect_wr(2, 'h22, 1); expect_wr(2, 'h23, 6);
        expect_wr(2, 'h24, 1); expect_wr(3, 'h31, 2); expect_wr(3, 'h32, 1);
        wait_beats(2, 50);
        @(posedge clk);
        force_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_stall_wr_en", int'(fifo_wr_en), 0);
            check("t3_stall_ready", int'(req_ready), 0);
            check("t3_stall_grant", int'(grant_id), 2);
            @(posedge clk);
        end
        force_full = 1'b0;
        wait_drain(50);

        // req0 drops valid after one beat; served again only after req3
        do_reset();
        offer(0, 'h01); offer(1, 'h11); offer(1, 'h12); offer(3, 'h31); offer(3, 'h32);
        expect_wr(0, 'h01, 0); expect_wr(1, 'h11, 3); expect_wr(1, 'h12, 1);
        expect_wr(3, 'h31, 3); expect_wr(3, 'h32, 1); expect_wr(0, 'h02, 3);
        wait_beats(2, 50);
        offer(0, 'h02);
        wait_drain(100);

        // Reset mid-burst, then all valid: req0 wins first
        do_reset();
        for (int k = 0; k < 4; k++) offer(1, 'h10 + k);
        expect_wr(1, 'h10, 0); expect_wr(1, 'h11, 1); expect_wr(0, 'h01, 3);
        expect_wr(1, 'h12, 3); expect_wr(1, 'h13, 1); expect_wr(2, 'h21, 3);
        expect_wr(3, 'h31, 3);
        wait_beats(2, 50);
        @(posedge clk);
        offer(0, 'h01); offer(2, 'h21); offer(3, 'h31);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_wr_en", int'(fifo_wr_en), 0);
        check("t5_rst_ready", int'(req_ready), 0);
        check("t5_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t5_post_wr_en", int'(fifo_wr_en), 0);
        check("t5_post_busy", int'(busy), 0);
        check("t5_post_ready", int'(req_ready), 0);
        check("t5_post_grant", int'(grant_id), 0);
        wait_drain(100);

        // 16-entry FIFO model: 15 accepted, stall, one read admits byte 16
        do_reset();
        use_fifo = 1'b1;
        for (int k = 0; k < 20; k++) offer(3, 'hC0 + k);
        for (int k = 0; k < 16; k++) begin
            expect_wr(3, 'hC0 + k, (k == 0 || k == 15) ? 0 : ((k % 4 == 0) ? 2 : 1));
        end
        begin
            int n = 0;
            while (fifo_cnt < 15 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("t6_filled", fifo_cnt, 15);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t6_stall_wr_en", int'(fifo_wr_en), 0);
            check("t6_stall_ready", int'(req_ready), 0);
        end
        check("t6_stall_busy", int'(busy), 1);
        check("t6_stall_grant", int'(grant_id), 3);
        @(posedge clk);
        rd_pulse = 1'b1;
        wait_drain(50);
        repeat (10) @(negedge clk);
        check("t6_remaining", src_q[3].size(), 4);
        check("t6_fifo_cnt", fifo_cnt, 15);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
